// File: rtl/riscv_pkg.sv
// ============================================================================
// Module      : riscv_pkg
// Description : Format and opcode constants shared by the immediate extender
//               and the instruction encoder, plus the encoder queue entry type.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package riscv_pkg;

    localparam logic [1:0] FMT_I = 2'b00;
    localparam logic [1:0] FMT_S = 2'b01;
    localparam logic [1:0] FMT_B = 2'b10;
    localparam logic [1:0] FMT_J = 2'b11;

    localparam logic [6:0] OP_IMM    = 7'h13;
    localparam logic [6:0] OP_STORE  = 7'h23;
    localparam logic [6:0] OP_BRANCH = 7'h63;
    localparam logic [6:0] OP_JAL    = 7'h6F;

    typedef struct packed {
        logic        err;
        logic [31:0] instr;
    } enc_entry_t;

endpackage

`default_nettype wire

// File: rtl/imm_pack.sv
// ============================================================================
// Module      : imm_pack
// Description : Combinational I/S/B/J packer with optional immediate range
//               check (INSTR_ENCODER_RANGE_CHECK_EN).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module imm_pack
    import riscv_pkg::*;
(
    input  logic [1:0]  src,
    input  logic [6:0]  opcode,
    input  logic [4:0]  rd,
    input  logic [2:0]  funct3,
    input  logic [4:0]  rs1,
    input  logic [4:0]  rs2,
    input  logic [31:0] imm,
    output logic [31:0] instr,
    output logic        err
);

    always_comb begin
        instr = '0;
        case (src)
            FMT_I:   instr = {imm[11:0], rs1, funct3, rd, opcode};
            FMT_S:   instr = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
            FMT_B:   instr = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode};
            default: instr = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode};
        endcase
    end

`ifdef INSTR_ENCODER_RANGE_CHECK_EN
    logic w_ext_is, w_ext_b, w_ext_j;

    // Upper bits must all match the sign bit the format can encode.
    assign w_ext_is = (&imm[31:11]) | ~(|imm[31:11]);
    assign w_ext_b  = (&imm[31:12]) | ~(|imm[31:12]);
    assign w_ext_j  = (&imm[31:20]) | ~(|imm[31:20]);

    always_comb begin
        err = 1'b0;
        case (src)
            FMT_I, FMT_S: err = ~w_ext_is;
            FMT_B:        err = ~w_ext_b | imm[0];
            default:      err = ~w_ext_j | imm[0];
        endcase
    end
`else
    logic w_unused_imm;

    assign w_unused_imm = ^imm[31:21];
    assign err          = 1'b0;
`endif

endmodule

`default_nettype wire

// File: rtl/instr_encoder.sv
// ============================================================================
// Module      : instr_encoder
// Description : RISC-V immediate encoder with valid/ready handshake, a 2-entry
//               output FIFO and accept/error counters. Range checking is
//               enabled by INSTR_ENCODER_RANGE_CHECK_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module instr_encoder
    import riscv_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       src,
    input  logic [6:0]       opcode,
    input  logic [4:0]       rd,
    input  logic [2:0]       funct3,
    input  logic [4:0]       rs1,
    input  logic [4:0]       rs2,
    input  logic [31:0]      imm,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_instr,
    output logic             out_err,
    output logic [CNT_W-1:0] enc_cnt,
    output logic [CNT_W-1:0] err_cnt
);

    enc_entry_t       r_mem [2];
    logic             r_wr_ptr;
    logic             r_rd_ptr;
    logic [1:0]       r_count;
    logic [CNT_W-1:0] r_enc_cnt;
    logic [31:0]      w_instr;
    logic             w_err;
    logic             w_push;
    logic             w_pop;
    enc_entry_t       w_head;

    imm_pack u_imm_pack (
        .src    (src),
        .opcode (opcode),
        .rd     (rd),
        .funct3 (funct3),
        .rs1    (rs1),
        .rs2    (rs2),
        .imm    (imm),
        .instr  (w_instr),
        .err    (w_err)
    );

    // in_ready depends only on stored occupancy, never on out_ready.
    assign in_ready  = (r_count != 2'd2) && !reset;
    assign out_valid = (r_count != 2'd0);
    assign w_push    = in_valid && in_ready;
    assign w_pop     = out_valid && out_ready;
    assign w_head    = r_mem[r_rd_ptr];
    assign out_instr = w_head.instr;
    assign out_err   = w_head.err;
    assign enc_cnt   = r_enc_cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_mem[0]  <= '0;
            r_mem[1]  <= '0;
            r_wr_ptr  <= 1'b0;
            r_rd_ptr  <= 1'b0;
            r_count   <= 2'd0;
            r_enc_cnt <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= '{err: w_err, instr: w_instr};
                r_wr_ptr        <= ~r_wr_ptr;
                r_enc_cnt       <= r_enc_cnt + CNT_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

`ifdef INSTR_ENCODER_RANGE_CHECK_EN
    logic [CNT_W-1:0] r_err_cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_err_cnt <= '0;
        end else if (w_push && w_err) begin
            r_err_cnt <= r_err_cnt + CNT_W'(1);
        end
    end

    assign err_cnt = r_err_cnt;
`else
    assign err_cnt = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_instr_encoder.sv
// ============================================================================
// Module      : tb_instr_encoder
// Description : Scoreboard bench for instr_encoder; directed vectors, expected
//               entries queued on accept and compared by a separate monitor.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_instr_encoder;

`ifdef INSTR_ENCODER_RANGE_CHECK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [1:0]  src = '0;
    logic [6:0]  opcode = '0;
    logic [4:0]  rd = '0;
    logic [2:0]  funct3 = '0;
    logic [4:0]  rs1 = '0;
    logic [4:0]  rs2 = '0;
    logic [31:0] imm = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_instr;
    logic        out_err;
    logic [15:0] enc_cnt;
    logic [15:0] err_cnt;

    int errors = 0;
    int checks = 0;
    logic [32:0] sb [$];

    instr_encoder #(.CNT_W(16)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .src       (src),
        .opcode    (opcode),
        .rd        (rd),
        .funct3    (funct3),
        .rs1       (rs1),
        .rs2       (rs2),
        .imm       (imm),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_instr (out_instr),
        .out_err   (out_err),
        .enc_cnt   (enc_cnt),
        .err_cnt   (err_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    // Monitor: head observed at negedge with out_ready high will pop at next edge.
    always @(negedge clk) begin
        if (!reset && out_valid && out_ready) begin
            logic [32:0] e;
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL pop_unexpected: got %08h expected none", out_instr);
            end else begin
                e = sb.pop_front();
                if ({out_err, out_instr} !== e) begin
                    errors++;
                    $display("FAIL pop_data: got err=%0b instr=%08h expected err=%0b instr=%08h",
                             out_err, out_instr, e[32], e[31:0]);
                end
            end
        end
    end

    task automatic send(input logic [1:0] s, input logic [6:0] op, input logic [4:0] d,
                        input logic [2:0] f3, input logic [4:0] r1, input logic [4:0] r2,
                        input logic [31:0] im, input logic [31:0] exp_instr, input logic exp_err);
        bit done = 0;
        src = s; opcode = op; rd = d; funct3 = f3; rs1 = r1; rs2 = r2; imm = im;
        in_valid = 1'b1;
        for (int i = 0; i < 50 && !done; i++) begin
            @(negedge clk);
            if (in_ready) begin
                sb.push_back({exp_err, exp_instr});
                done = 1;
            end
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        if (!done) begin
            errors++;
            checks++;
            $display("FAIL accept_timeout: got in_ready=0 expected 1");
        end
    endtask

    task automatic drain();
        out_ready = 1'b1;
        for (int i = 0; i < 20 && sb.size() != 0; i++) @(posedge clk);
        #1;
        check("drain_empty", 32'(sb.size()), 32'd0);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_instr", out_instr, 32'd0);
        check("rst_out_err", 32'(out_err), 32'd0);
        check("rst_enc_cnt", 32'(enc_cnt), 32'd0);
        check("rst_err_cnt", 32'(err_cnt), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd0);
        reset = 1'b0;
        #1;
        check("in_ready_after_rst", 32'(in_ready), 32'd1);

        out_ready = 1'b1;
        send(2'b00, 7'h13, 5'd5, 3'd0, 5'd6, 5'd0, 32'hFFFF_FFFF, 32'hFFF3_0293, 1'b0);
        check("enc_cnt_I", 32'(enc_cnt), 32'd1);
        send(2'b01, 7'h23, 5'd0, 3'd2, 5'd2, 5'd7, 32'h0000_0008, 32'h0071_2423, 1'b0);
        send(2'b10, 7'h63, 5'd0, 3'd0, 5'd1, 5'd2, 32'hFFFF_FFFC, 32'hFE20_8EE3, 1'b0);
        send(2'b11, 7'h6F, 5'd1, 3'd0, 5'd0, 5'd0, 32'h0000_0800, 32'h0010_00EF, 1'b0);
        drain();
        check("enc_cnt_4", 32'(enc_cnt), 32'd4);

        send(2'b00, 7'h13, 5'd0, 3'd0, 5'd0, 5'd0, 32'h0000_0800, 32'h8000_0013, CHK);
        check("err_cnt_I", 32'(err_cnt), CHK ? 32'd1 : 32'd0);
        send(2'b10, 7'h63, 5'd0, 3'd0, 5'd0, 5'd0, 32'h0000_0003, 32'h0000_0163, CHK);
        check("err_cnt_B", 32'(err_cnt), CHK ? 32'd2 : 32'd0);
        drain();

        // Backpressure: two fill the queue, third is held until a slot frees.
        reset = 1'b1; @(posedge clk); #1; reset = 1'b0;
        out_ready = 1'b0;
        send(2'b00, 7'h13, 5'd1, 3'd0, 5'd0, 5'd0, 32'h0000_0001, 32'h0010_0093, 1'b0);
        send(2'b00, 7'h13, 5'd2, 3'd0, 5'd0, 5'd0, 32'h0000_0002, 32'h0020_0113, 1'b0);
        @(negedge clk);
        check("full_in_ready", 32'(in_ready), 32'd0);
        check("full_head_stable", out_instr, 32'h0010_0093);
        @(posedge clk); #1;
        out_ready = 1'b1;
        fork
            send(2'b00, 7'h13, 5'd3, 3'd0, 5'd0, 5'd0, 32'h0000_0003, 32'h0030_0193, 1'b0);
            for (int k = 0; k < 3; k++) begin
                @(negedge clk);
                check("bp_consecutive_valid", 32'(out_valid), 32'd1);
            end
        join
        drain();
        check("bp_enc_cnt", 32'(enc_cnt), 32'd3);

        // Reset with two queued entries discards them.
        out_ready = 1'b0;
        send(2'b00, 7'h13, 5'd4, 3'd0, 5'd0, 5'd0, 32'h0000_0004, 32'h0040_0213, 1'b0);
        send(2'b00, 7'h13, 5'd5, 3'd0, 5'd0, 5'd0, 32'h0000_0005, 32'h0050_0293, 1'b0);
        reset = 1'b1;
        sb.delete();
        @(posedge clk); #1;
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        check("midrst_enc_cnt", 32'(enc_cnt), 32'd0);
        check("midrst_in_ready", 32'(in_ready), 32'd0);
        reset = 1'b0;
        #1;
        check("midrst_in_ready_after", 32'(in_ready), 32'd1);
        out_ready = 1'b1;
        send(2'b01, 7'h23, 5'd0, 3'd2, 5'd2, 5'd7, 32'h0000_0008, 32'h0071_2423, 1'b0);
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/instr_encoder.md
# instr_encoder

Sequential RISC-V instruction encoder: accepts register fields, an opcode, a format select and a full 32-bit immediate, then scatters the immediate into I/S/B/J instruction bit positions. It is the inverse of the core's immediate sign-extender: `SE(encode(x)) == x` for every in-range immediate. It sits between the test/program loader and instruction memory, with valid/ready on both sides and a 2-entry output queue.

## Interface
- `CNT_W`, default 16: width of the accepted-instruction and error counters.
- `clk`  input  1  clock, rising edge.
- `reset`  input  1  synchronous, active-high reset.
- `in_valid`  input  1  request present.
- `in_ready`  output  1  encoder can accept this cycle.
- `src`  input  2  format: 00 I, 01 S, 10 B, 11 J (same encoding as the extender).
- `opcode`  input  7  placed in instr[6:0].
- `rd`  input  5  used by I and J formats.
- `funct3`  input  3  used by I, S and B formats.
- `rs1`  input  5  used by I, S and B formats.
- `rs2`  input  5  used by S and B formats.
- `imm`  input  32  full signed immediate (byte offset for B and J).
- `out_valid`  output  1  queue head valid.
- `out_ready`  input  1  consumer takes the head.
- `out_instr`  output  32  encoded instruction.
- `out_err`  output  1  head immediate was out of range or misaligned.
- `enc_cnt`  output  CNT_W  instructions accepted since reset.
- `err_cnt`  output  CNT_W  erroneous instructions accepted since reset.

## Operation
- Packing, by format:
  - I: {imm[11:0], rs1, funct3, rd, opcode}.
  - S: {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode}.
  - B: {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode}.
  - J: {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode}.
- Range rules:
  - I and S: imm[31:11] must be all-equal.
  - B: imm[31:12] must be all-equal and imm[0] must be 0.
  - J: imm[31:20] must be all-equal and imm[0] must be 0.
  - A violation sets the err bit. The packed word is still the truncated encoding.
- Accept occurs when `in_valid && in_ready`. The packed word and err bit are pushed into the 2-entry FIFO. `enc_cnt` increments, and `err_cnt` increments if err is set.
- Pop occurs when `out_valid && out_ready`.
- `in_ready = (count != 2) && !reset`. There is no combinational path from `out_ready` to `in_ready`.
- Simultaneous push and pop at count 1 leaves count at 1 and preserves order.
- Order is strictly FIFO. The head is stable while `out_valid && !out_ready`.
- Counters wrap modulo 2^CNT_W.

## Timing
- Latency: a request accepted at edge N is visible on `out_*` after edge N. Worst case it is head one cycle after the previous entry pops.
- Throughput: one instruction per cycle when `out_ready` is held high.
- Reset (sampled at an edge):
  - FIFO is emptied and pointers are zeroed.
  - `out_valid`=0, `out_instr`=0, `out_err`=0, `enc_cnt`=0, `err_cnt`=0.
  - `in_ready`=0 while reset is high and 1 the first cycle after.
- Reset mid-operation discards queued entries with no pop observed.
- Full: when count=2, `in_ready` is 0. The upstream must hold its request stable until it is accepted.
- Empty: when count=0, `out_valid` is 0 and `out_instr` holds its last value (don't care).

## Configuration
- `INSTR_ENCODER_RANGE_CHECK_EN` defined:
  - Range checker is instantiated.
  - `out_err` and `err_cnt` behave as described above.
- Not defined:
  - No check logic is built.
  - `out_err` is tied 0 and `err_cnt` is tied 0.
  - Packing is unchanged, so out-of-range immediates are silently truncated.

## Structure
- Shared package `riscv_pkg` holds:
  - Format constants FMT_I=2'b00, FMT_S=2'b01, FMT_B=2'b10, FMT_J=2'b11, shared with the extender.
  - Opcode constants OP_IMM=7'h13, OP_STORE=7'h23, OP_BRANCH=7'h63, OP_JAL=7'h6F.
- One sub-module, `imm_pack`: purely combinational packer plus range check, taking fields in and giving {instr, err} out.
- The top level holds the FIFO, handshake logic and counters.

## Test plan
- I-type: src=00, opcode=13, rd=5, funct3=0, rs1=6, imm=FFFFFFFF -> out_instr=FFF30293, out_err=0, enc_cnt=1.
- S and B types:
  - S: src=01, opcode=23, funct3=2, rs1=2, rs2=7, imm=8 -> 00712423.
  - B: src=10, opcode=63, funct3=0, rs1=1, rs2=2, imm=FFFFFFFC -> FE208EE3.
- J-type: src=11, opcode=6F, rd=1, imm=00000800 -> 001000EF. Feeding this result through the extender with src=11 returns 00000800.
- Range errors (macro defined):
  - I with imm=00000800 -> out_err=1, err_cnt=1.
  - B with imm=3 -> out_err=1, err_cnt=2.
  - Without the macro, both cases give out_err=0 and err_cnt=0.
- Backpressure:
  - Hold out_ready=0 and offer 3 requests: two are accepted, then in_ready=0 and the third is held.
  - Raise out_ready: the three results appear in order on consecutive cycles, and enc_cnt=3.
- Reset mid-operation: assert reset with 2 entries queued -> next cycle out_valid=0, enc_cnt=0, and in_ready=1 after reset drops.
